// File: rtl/cnn_window_sequencer.sv
// cnn_window_sequencer
// Sequences one binary 3x3 convolution pass over an 8x8 image. A start request
// from the SPI clock domain launches the pass. The block snapshots the image and
// streams the 36 windows to a processing element (PE) over a valid/ready
// handshake. It then folds the PE scores into a saturating hit count and a peak
// score.
//
// Ports
//   i_Clk, i_Rst_n        system clock, asynchronous active-low reset
//   i_start               start request (asynchronous to i_Clk)
//   i_row00..i_row07      image rows, bit 7 is column 0
//   i_threshold           minimum score counted as a hit
//   o_win_valid, o_win    window offer to the PE (registered)
//   i_win_ready           PE accepts the current window
//   i_score_valid, i_score  PE score strobe and value (0..9)
//   o_busy                pass in progress (LOAD/ISSUE/DRAIN)
//   o_done                one-cycle completion pulse
//   o_result              hit count of the last pass, saturating at 15
//   o_max_score           peak score of the last pass
module cnn_window_sequencer #(
    parameter int unsigned N_WIN = 36
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_start,
    input  logic [7:0] i_row00,
    input  logic [7:0] i_row01,
    input  logic [7:0] i_row02,
    input  logic [7:0] i_row03,
    input  logic [7:0] i_row04,
    input  logic [7:0] i_row05,
    input  logic [7:0] i_row06,
    input  logic [7:0] i_row07,
    input  logic [3:0] i_threshold,
    output logic       o_win_valid,
    output logic [8:0] o_win,
    input  logic       i_win_ready,
    input  logic       i_score_valid,
    input  logic [3:0] i_score,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_result,
    output logic [3:0] o_max_score
);

    localparam logic [5:0] NWinCnt = 6'(N_WIN);

    typedef enum logic [2:0] {StIdle, StLoad, StIssue, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       sync_q;
    logic             start_edge;
    logic [7:0][7:0]  rows_q, rows_d;
    logic [2:0]       r_q, r_d, c_q, c_d;
    logic [5:0]       resp_q, resp_d;
    logic [3:0]       hit_q, hit_d, max_q, max_d, thr_q, thr_d;
    logic [3:0]       result_q, result_d, max_out_q, max_out_d;
    logic             valid_q, valid_d;
    logic [8:0]       win_q, win_d;

    // Window at top-left (r, c): MSB is row r column c, row-major over the 3x3.
    function automatic logic [8:0] window(input logic [7:0][7:0] rows,
                                          input logic [2:0] r, input logic [2:0] c);
        logic [8:0] w;
        logic [2:0] ri, ci;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ri = r + 3'(i);
                ci = 3'd7 - c - 3'(j);
                w  = {w[7:0], rows[ri][ci]};
            end
        end
        return w;
    endfunction

    // sync_q[1:0] is the synchronizer, sync_q[2] holds the previous value.
    assign start_edge = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        r_d       = r_q;
        c_d       = c_q;
        resp_d    = resp_q;
        hit_d     = hit_q;
        max_d     = max_q;
        thr_d     = thr_q;
        result_d  = result_q;
        max_out_d = max_out_q;
        valid_d   = valid_q;
        win_d     = win_q;

        // Scores are folded in before the state decode so that DRAIN can
        // finish in the same cycle as the final score.
        if ((state_q == StIssue || state_q == StDrain) && i_score_valid) begin
            resp_d = resp_q + 6'd1;
            if (i_score >= thr_q && hit_q != 4'd15) begin
                hit_d = hit_q + 4'd1;
            end
            if (i_score > max_q) begin
                max_d = i_score;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                rows_d  = {i_row07, i_row06, i_row05, i_row04,
                           i_row03, i_row02, i_row01, i_row00};
                r_d     = '0;
                c_d     = '0;
                resp_d  = '0;
                hit_d   = '0;
                max_d   = '0;
                thr_d   = i_threshold;
                valid_d = 1'b1;
                win_d   = window(rows_d, 3'd0, 3'd0);
                state_d = StIssue;
            end
            StIssue: begin
                if (valid_q && i_win_ready) begin
                    if (r_q == 3'd5 && c_q == 3'd5) begin
                        valid_d = 1'b0;
                        state_d = StDrain;
                    end else begin
                        if (c_q == 3'd5) begin
                            c_d = '0;
                            r_d = r_q + 3'd1;
                        end else begin
                            c_d = c_q + 3'd1;
                        end
                        win_d = window(rows_q, r_d, c_d);
                    end
                end
            end
            StDrain: begin
                if (resp_d == NWinCnt) begin
                    result_d  = hit_d;
                    max_out_d = max_d;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= StIdle;
            sync_q    <= '0;
            rows_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            resp_q    <= '0;
            hit_q     <= '0;
            max_q     <= '0;
            thr_q     <= '0;
            result_q  <= '0;
            max_out_q <= '0;
            valid_q   <= 1'b0;
            win_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[1:0], i_start};
            rows_q    <= rows_d;
            r_q       <= r_d;
            c_q       <= c_d;
            resp_q    <= resp_d;
            hit_q     <= hit_d;
            max_q     <= max_d;
            thr_q     <= thr_d;
            result_q  <= result_d;
            max_out_q <= max_out_d;
            valid_q   <= valid_d;
            win_q     <= win_d;
        end
    end

    assign o_win_valid = valid_q;
    assign o_win       = win_q;
    assign o_busy      = (state_q == StLoad) || (state_q == StIssue) || (state_q == StDrain);
    assign o_done      = (state_q == StDone);
    assign o_result    = result_q;
    assign o_max_score = max_out_q;

endmodule

// File: tb/tb_cnn_window_sequencer.sv
module tb_cnn_window_sequencer;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n;
    logic       i_start;
    logic [7:0] img [8];
    logic [7:0] i_row00, i_row01, i_row02, i_row03, i_row04, i_row05, i_row06, i_row07;
    logic [3:0] i_threshold;
    logic       o_win_valid;
    logic [8:0] o_win;
    logic       i_win_ready;
    logic       i_score_valid;
    logic [3:0] i_score;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_result;
    logic [3:0] o_max_score;

    int checks = 0;
    int errors = 0;

    // PE / monitor state
    int         cyc = 0;
    int         acc_cnt;
    int         done_cnt;
    int         valid_cycles;
    int         last_score_cyc;
    int         done_cyc;
    int         pe_mode = 0;     // 0: fixed 2-cycle latency, 1: hold until all windows taken
    int         ready_mode = 0;  // 0: ready tied high, 1: toggle every cycle
    logic [8:0] win_log [36];
    int         score_q [$];
    int         due_q [$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_win = '0;

    assign i_row00 = img[0];
    assign i_row01 = img[1];
    assign i_row02 = img[2];
    assign i_row03 = img[3];
    assign i_row04 = img[4];
    assign i_row05 = img[5];
    assign i_row06 = img[6];
    assign i_row07 = img[7];

    cnn_window_sequencer #(.N_WIN(36)) dut (
        .i_Clk         (i_Clk),
        .i_Rst_n       (i_Rst_n),
        .i_start       (i_start),
        .i_row00       (i_row00),
        .i_row01       (i_row01),
        .i_row02       (i_row02),
        .i_row03       (i_row03),
        .i_row04       (i_row04),
        .i_row05       (i_row05),
        .i_row06       (i_row06),
        .i_row07       (i_row07),
        .i_threshold   (i_threshold),
        .o_win_valid   (o_win_valid),
        .o_win         (o_win),
        .i_win_ready   (i_win_ready),
        .i_score_valid (i_score_valid),
        .i_score       (i_score),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_max_score   (o_max_score)
    );

    always #5 i_Clk = ~i_Clk;

    // Reference window built from column triplets of the bench image.
    function automatic logic [8:0] exp_window(input int k);
        int r, c;
        logic [7:0] t0, t1, t2;
        r  = k / 6;
        c  = k % 6;
        t0 = (img[3'(r)]     >> (5 - c)) & 8'h07;
        t1 = (img[3'(r + 1)] >> (5 - c)) & 8'h07;
        t2 = (img[3'(r + 2)] >> (5 - c)) & 8'h07;
        return {t0[2:0], t1[2:0], t2[2:0]};
    endfunction

    // PE model and monitor: drives on the falling edge, DUT samples on the rising edge.
    always @(negedge i_Clk) begin
        logic [8:0] nw;
        cyc++;
        if (!i_Rst_n) begin
            score_q.delete();
            due_q.delete();
            prev_stall    = 1'b0;
            i_score_valid = 1'b0;
            i_score       = '0;
            i_win_ready   = 1'b1;
        end else begin
            if (prev_stall) begin
                checks++;
                if (o_win_valid !== 1'b1 || o_win !== prev_win) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b win=%h, required valid=1 win=%h",
                             o_win_valid, o_win, prev_win);
                end
            end
            if (o_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_win_valid === 1'b1) valid_cycles++;
            if (ready_mode == 1) i_win_ready = ~i_win_ready;
            else i_win_ready = 1'b1;
            i_score_valid = 1'b0;
            if (score_q.size() > 0 &&
                ((pe_mode == 0 && due_q[0] <= cyc) || (pe_mode == 1 && acc_cnt == 36))) begin
                i_score_valid  = 1'b1;
                i_score        = 4'(score_q.pop_front());
                void'(due_q.pop_front());
                last_score_cyc = cyc;
            end
            if (o_win_valid === 1'b1 && i_win_ready) begin
                if (acc_cnt < 36) win_log[acc_cnt] = o_win;
                acc_cnt++;
                nw = ~o_win;
                score_q.push_back($countones(nw));
                due_q.push_back(cyc + 2);
            end
            prev_stall = (o_win_valid === 1'b1) && !i_win_ready;
            prev_win   = o_win;
        end
    end

    task automatic tick();
        @(negedge i_Clk);
        #1;
    endtask

    task automatic clear_stats();
        acc_cnt        = 0;
        done_cnt       = 0;
        valid_cycles   = 0;
        last_score_cyc = -1;
        done_cyc       = -1;
    endtask

    task automatic set_image(input logic [7:0] v);
        for (int i = 0; i < 8; i++) img[i] = v;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: no o_done in %0d cycles", name, n);
        end
        repeat (4) tick();
    endtask

    task automatic check_result(input string name, input logic [3:0] res, input logic [3:0] mx);
        checks++;
        if (o_result !== res || o_max_score !== mx || done_cnt != 1) begin
            errors++;
            $display("FAIL %s: result=%0d max=%0d dones=%0d, required result=%0d max=%0d dones=1",
                     name, o_result, o_max_score, done_cnt, res, mx);
        end
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        i_start = 1'b0;
        i_threshold = '0;
        set_image(8'h00);
        repeat (3) tick();
        checks++;
        if ({o_win_valid, o_win, o_busy, o_done, o_result, o_max_score} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: %h, required 0",
                     {o_win_valid, o_win, o_busy, o_done, o_result, o_max_score});
        end
        i_Rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_busy !== 1'b0 || o_win_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", o_busy, o_win_valid);
        end
    endtask

    task automatic test_zero_image();
        set_image(8'h00);
        i_threshold = 4'd9;
        pe_mode = 0;
        ready_mode = 0;
        clear_stats();
        i_start = 1'b1;            // sampled at edge n
        tick();                    // after n
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_n: busy=%b, required 0", o_busy);
        end
        tick();                    // after n+1
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_n1: busy=%b, required 0", o_busy);
        end
        tick();                    // after n+2: LOAD
        checks++;
        if (o_busy !== 1'b1 || o_win_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_n2: busy=%b valid=%b, required 1 0", o_busy, o_win_valid);
        end
        tick();                    // after n+3: ISSUE
        checks++;
        if (o_busy !== 1'b1 || o_win_valid !== 1'b1 || o_win !== 9'h000) begin
            errors++;
            $display("FAIL lat_n3: busy=%b valid=%b win=%h, required 1 1 000",
                     o_busy, o_win_valid, o_win);
        end
        wait_done("zero");
        check_result("zero_result", 4'd15, 4'd9);
        checks++;
        if (valid_cycles != 36 || done_cyc != last_score_cyc + 1) begin
            errors++;
            $display("FAIL zero_timing: valid_cycles=%0d done_at=%0d, required 36 and %0d",
                     valid_cycles, done_cyc, last_score_cyc + 1);
        end
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_all_ones();
        set_image(8'hFF);
        i_threshold = 4'd1;
        clear_stats();
        pulse_start();
        wait_done("ones");
        check_result("ones_result", 4'd0, 4'd0);
    endtask

    task automatic test_backpressure();
        set_image(8'h00);
        img[0] = 8'hE0;
        img[1] = 8'hE0;
        img[2] = 8'hE0;
        i_threshold = 4'd5;
        ready_mode = 1;
        clear_stats();
        pulse_start();
        wait_done("bp");
        ready_mode = 0;
        checks++;
        if (win_log[0] !== 9'h1FF || win_log[1] !== 9'h1B6) begin
            errors++;
            $display("FAIL bp_first_windows: %h %h, required 1ff 1b6", win_log[0], win_log[1]);
        end
        checks++;
        if (acc_cnt != 36 || valid_cycles <= 36) begin
            errors++;
            $display("FAIL bp_count: accepted=%0d valid_cycles=%0d, required 36 and >36",
                     acc_cnt, valid_cycles);
        end
        for (int k = 0; k < 36; k++) begin
            checks++;
            if (win_log[k] !== exp_window(k)) begin
                errors++;
                $display("FAIL bp_win%0d: %h, required %h", k, win_log[k], exp_window(k));
            end
        end
        check_result("bp_result", 4'd15, 4'd9);
    endtask

    task automatic test_out_of_band();
        int n = 0;
        set_image(8'h00);
        i_threshold = 4'd9;
        clear_stats();
        pulse_start();
        while (valid_cycles < 5 && n < 50) begin
            tick();
            n++;
        end
        pulse_start();             // lands mid-ISSUE, must be dropped
        wait_done("oob");
        repeat (20) tick();
        checks++;
        if (done_cnt != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL oob_single_done: dones=%0d busy=%b, required 1 0", done_cnt, o_busy);
        end
        set_image(8'hAA);
        i_threshold = 4'd7;
        clear_stats();
        pulse_start();
        wait_done("fresh");
        check_result("fresh_result", 4'd0, 4'd6);
    endtask

    task automatic test_reset_mid_pass();
        int n = 0;
        set_image(8'h00);
        i_threshold = 4'd9;
        clear_stats();
        pulse_start();
        wait_done("pre_rst");
        check_result("pre_rst_result", 4'd15, 4'd9);
        clear_stats();
        pulse_start();
        while (acc_cnt < 20 && n < 100) begin
            tick();
            n++;
        end
        i_Rst_n = 1'b0;
        #1;
        checks++;
        if ({o_win_valid, o_win, o_busy, o_done, o_result, o_max_score} !== 20'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: %h, required 0",
                     {o_win_valid, o_win, o_busy, o_done, o_result, o_max_score});
        end
        repeat (3) tick();
        i_Rst_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid_no_done: dones=%0d, required 0", done_cnt);
        end
        clear_stats();
        pulse_start();
        wait_done("post_rst");
        checks++;
        if (acc_cnt != 36) begin
            errors++;
            $display("FAIL post_rst_windows: accepted=%0d, required 36", acc_cnt);
        end
        check_result("post_rst_result", 4'd15, 4'd9);
    endtask

    task automatic test_score_delay();
        int n = 0;
        set_image(8'h00);
        img[7] = 8'h81;            // outside every window row range except r=5
        i_threshold = 4'd9;
        pe_mode = 1;
        clear_stats();
        pulse_start();
        while (acc_cnt < 36 && n < 100) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (o_busy !== 1'b1 || o_win_valid !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL delay_drain: busy=%b valid=%b done=%b, required 1 0 0",
                     o_busy, o_win_valid, o_done);
        end
        wait_done("delay");
        pe_mode = 0;
        checks++;
        if (done_cyc != last_score_cyc + 1) begin
            errors++;
            $display("FAIL delay_done_timing: done_at=%0d, required %0d",
                     done_cyc, last_score_cyc + 1);
        end
        // Row 7 bits 7 and 0 touch windows (5,0) and (5,5): 34 nines and two eights.
        check_result("delay_result", 4'd15, 4'd9);
    endtask

    initial begin
        test_reset();
        test_zero_image();
        test_all_ones();
        test_backpressure();
        test_out_of_band();
        test_reset_mid_pass();
        test_score_delay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
